// File: rtl/time_set_pkg.sv
// Shared types, field codes and wrap helpers for the time-set controller.
package time_set_pkg;

  localparam int HOURS_W  = 5;
  localparam int MINSEC_W = 6;

  localparam logic [HOURS_W-1:0]  HOURS_MAX  = 5'd23;
  localparam logic [MINSEC_W-1:0] MINSEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOUR   = 3'd1,
    MIN    = 3'd2,
    SEC    = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  // Wrap is an explicit compare-and-set so no value ever relies on overflow.
  function automatic logic [HOURS_W-1:0] hours_inc(input logic [HOURS_W-1:0] v);
    return (v >= HOURS_MAX) ? '0 : v + 5'd1;
  endfunction

  function automatic logic [HOURS_W-1:0] hours_dec(input logic [HOURS_W-1:0] v);
    return (v == '0 || v > HOURS_MAX) ? HOURS_MAX : v - 5'd1;
  endfunction

  function automatic logic [MINSEC_W-1:0] minsec_inc(input logic [MINSEC_W-1:0] v);
    return (v >= MINSEC_MAX) ? '0 : v + 6'd1;
  endfunction

  function automatic logic [MINSEC_W-1:0] minsec_dec(input logic [MINSEC_W-1:0] v);
    return (v == '0 || v > MINSEC_MAX) ? MINSEC_MAX : v - 6'd1;
  endfunction

  // Field code shown to the display for a given state.
  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      HOUR:    return FIELD_HOUR;
      MIN:     return FIELD_MIN;
      SEC:     return FIELD_SEC;
      default: return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stable-count debouncer and
// a one-cycle press pulse on the accepted 0->1 transition.
// press is combinational from flops and is high during the cycle whose
// closing edge flips the debounced level, so a consumer registering it sees
// the press DEBOUNCE_CYCLES+2 edges after the raw input is first sampled high.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  assign flip  = (sync2 != level) && (cnt == CNT_LAST);
  assign press = flip && sync2;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounced level flips only after a full run of differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (flip) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Time-set controller: edits an hours/minutes/seconds value from three
// push-buttons and hands it to the time-of-day counter with a load pulse.
// Optional blink output is built when TIME_SET_BLINK_EN is defined.
//
// Handshake: load is a single-cycle strobe with no back-pressure; the
// counter must take load_hours/minutes/seconds in the cycle load is high.
// load_* hold their values at all other times.
module time_set_controller
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1024
`ifdef TIME_SET_BLINK_EN
  , parameter int BLINK_CYCLES  = 256
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set,
  input  logic                op1,
  input  logic                op2,
  input  logic [HOURS_W-1:0]  cur_hours,
  input  logic [MINSEC_W-1:0] cur_minutes,
  input  logic [MINSEC_W-1:0] cur_seconds,
  output logic                load,
  output logic [HOURS_W-1:0]  load_hours,
  output logic [MINSEC_W-1:0] load_minutes,
  output logic [MINSEC_W-1:0] load_seconds,
  output logic                editing,
  output logic [1:0]          field,
  output logic [2:0]          fsm_state
`ifdef TIME_SET_BLINK_EN
  , output logic              blink
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic set_ev;
  logic op1_ev;
  logic op2_ev;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk(clk), .rst_n(reset), .raw(set), .press(set_ev));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_op1_db (
    .clk(clk), .rst_n(reset), .raw(op1), .press(op1_ev));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_op2_db (
    .clk(clk), .rst_n(reset), .raw(op2), .press(op2_ev));

  state_t              state_q;
  state_t              state_d;
  logic [HOURS_W-1:0]  hours_d;
  logic [MINSEC_W-1:0] minutes_d;
  logic [MINSEC_W-1:0] seconds_d;
  logic [TMO_W-1:0]    tmo_q;
  logic [TMO_W-1:0]    tmo_d;
  logic                any_ev;
  logic                op_up;
  logic                op_dn;

  // op1 and op2 together cancel each other; set is checked first and wins.
  assign any_ev = set_ev | op1_ev | op2_ev;
  assign op_up  = op1_ev & ~op2_ev;
  assign op_dn  = op2_ev & ~op1_ev;

  assign fsm_state = state_q;

  // Next state, edit values and idle timeout.
  always_comb begin
    state_d   = state_q;
    hours_d   = load_hours;
    minutes_d = load_minutes;
    seconds_d = load_seconds;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (set_ev) begin
          state_d   = HOUR;
          hours_d   = (cur_hours   > HOURS_MAX)  ? '0 : cur_hours;
          minutes_d = (cur_minutes > MINSEC_MAX) ? '0 : cur_minutes;
          seconds_d = (cur_seconds > MINSEC_MAX) ? '0 : cur_seconds;
        end
      end
      HOUR, MIN, SEC: begin
        if (any_ev) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (set_ev) begin
          case (state_q)
            HOUR:    state_d = MIN;
            MIN:     state_d = SEC;
            default: state_d = COMMIT;
          endcase
        end else if (op_up || op_dn) begin
          case (state_q)
            HOUR:    hours_d   = op_up ? hours_inc(load_hours)    : hours_dec(load_hours);
            MIN:     minutes_d = op_up ? minsec_inc(load_minutes) : minsec_dec(load_minutes);
            default: seconds_d = op_up ? minsec_inc(load_seconds) : minsec_dec(load_seconds);
          endcase
        end
      end
      COMMIT: begin
        tmo_d   = '0;
        state_d = IDLE;
      end
      default: begin
        tmo_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, edit registers and status outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      load_hours   <= '0;
      load_minutes <= '0;
      load_seconds <= '0;
      load         <= 1'b0;
      editing      <= 1'b0;
      field        <= FIELD_NONE;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      load_hours   <= hours_d;
      load_minutes <= minutes_d;
      load_seconds <= seconds_d;
      load         <= (state_d == COMMIT);
      editing      <= (state_d == HOUR) || (state_d == MIN) || (state_d == SEC);
      field        <= field_of(state_d);
    end
  end

`ifdef TIME_SET_BLINK_EN
  localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             edit_next;

  assign edit_next = (state_d == HOUR) || (state_d == MIN) || (state_d == SEC);

  // Blink restarts lit on each field entry or op press, dark outside editing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (!edit_next) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if ((state_d != state_q) || op1_ev || op2_ev) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLK_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller. Inputs are driven and outputs
// sampled on the falling edge; the design acts on the rising edge.
module tb_time_set_controller;
  import time_set_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       set;
  logic       op1;
  logic       op2;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic       editing;
  logic [1:0] field;
  logic [2:0] fsm_state;
`ifdef TIME_SET_BLINK_EN
  logic       blink;
`endif

  int checks    = 0;
  int errors    = 0;
  int load_seen = 0;

  time_set_controller #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES(1024)
`ifdef TIME_SET_BLINK_EN
    , .BLINK_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset(reset), .set(set), .op1(op1), .op2(op2),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
    .load_seconds(load_seconds), .editing(editing), .field(field),
    .fsm_state(fsm_state)
`ifdef TIME_SET_BLINK_EN
    , .blink(blink)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; set = 1'b0; op1 = 1'b0; op2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Hold the chosen buttons long enough to register, then release fully.
  task automatic push(input logic s, input logic a, input logic b);
    @(negedge clk);
    set = s; op1 = a; op2 = b;
    repeat (D + 3) @(negedge clk);
    set = 1'b0; op1 = 1'b0; op2 = 1'b0;
    repeat (D + 4) @(negedge clk);
  endtask

  task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hours = h; cur_minutes = m; cur_seconds = s;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0; set = 1'b0; op1 = 1'b0; op2 = 1'b0;
    set_cur(5'd0, 6'd0, 6'd0);
    repeat (2) @(negedge clk);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %0d expected 0", load); end
    checks++; if (load_hours !== 5'd0) begin errors++; $display("FAIL reset_hours: got %0d expected 0", load_hours); end
    checks++; if (load_minutes !== 6'd0) begin errors++; $display("FAIL reset_minutes: got %0d expected 0", load_minutes); end
    checks++; if (load_seconds !== 6'd0) begin errors++; $display("FAIL reset_seconds: got %0d expected 0", load_seconds); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL reset_editing: got %0d expected 0", editing); end
    checks++; if (field !== 2'd0) begin errors++; $display("FAIL reset_field: got %0d expected 0", field); end
    checks++; if (fsm_state !== 3'(IDLE)) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
    reset = 1'b1;
    repeat (D + 4) @(negedge clk);
    checks++; if (fsm_state !== 3'(IDLE)) begin errors++; $display("FAIL reset_no_event: got %0d expected %0d", fsm_state, IDLE); end
  endtask

  task automatic test_capture_latency();
    set_cur(5'd13, 6'd45, 6'd30);
    @(negedge clk);
    set = 1'b1;
    repeat (D + 1) @(negedge clk);
    checks++; if (field !== 2'd0) begin errors++; $display("FAIL latency_early: got field %0d expected 0", field); end
    @(negedge clk);
    checks++; if (field !== 2'd1) begin errors++; $display("FAIL latency_exact: got field %0d expected 1", field); end
    checks++; if (editing !== 1'b1) begin errors++; $display("FAIL capture_editing: got %0d expected 1", editing); end
    checks++; if (load_hours !== 5'd13) begin errors++; $display("FAIL capture_hours: got %0d expected 13", load_hours); end
    checks++; if (load_minutes !== 6'd45) begin errors++; $display("FAIL capture_minutes: got %0d expected 45", load_minutes); end
    checks++; if (load_seconds !== 6'd30) begin errors++; $display("FAIL capture_seconds: got %0d expected 30", load_seconds); end
    set = 1'b0;
    repeat (D + 4) @(negedge clk);
    checks++; if (field !== 2'd1) begin errors++; $display("FAIL release_no_event: got field %0d expected 1", field); end
  endtask

  task automatic test_glitch_simultaneous();
    @(negedge clk);
    op1 = 1'b1;
    repeat (2) @(negedge clk);
    op1 = 1'b0;
    repeat (D + 4) @(negedge clk);
    checks++; if (load_hours !== 5'd13) begin errors++; $display("FAIL glitch_ignored: got %0d expected 13", load_hours); end
    push(1'b0, 1'b1, 1'b1);
    checks++; if (load_hours !== 5'd13) begin errors++; $display("FAIL op1_op2_cancel: got %0d expected 13", load_hours); end
    checks++; if (field !== 2'd1) begin errors++; $display("FAIL op1_op2_field: got %0d expected 1", field); end
    push(1'b1, 1'b1, 1'b0);
    checks++; if (field !== 2'd2) begin errors++; $display("FAIL set_op1_field: got %0d expected 2", field); end
    checks++; if (load_hours !== 5'd13) begin errors++; $display("FAIL set_op1_hours: got %0d expected 13", load_hours); end
    checks++; if (load_minutes !== 6'd45) begin errors++; $display("FAIL set_op1_minutes: got %0d expected 45", load_minutes); end
    push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    checks++; if (field !== 2'd0) begin errors++; $display("FAIL glitch_exit_field: got %0d expected 0", field); end
  endtask

  task automatic test_wrap();
    set_cur(5'd23, 6'd0, 6'd59);
    push(1'b1, 1'b0, 1'b0);
    checks++; if (load_hours !== 5'd23) begin errors++; $display("FAIL wrap_capture_h: got %0d expected 23", load_hours); end
    push(1'b0, 1'b1, 1'b0);
    checks++; if (load_hours !== 5'd0) begin errors++; $display("FAIL wrap_hour_up: got %0d expected 0", load_hours); end
    push(1'b0, 1'b0, 1'b1);
    checks++; if (load_hours !== 5'd23) begin errors++; $display("FAIL wrap_hour_down: got %0d expected 23", load_hours); end
    push(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1);
    checks++; if (load_minutes !== 6'd59) begin errors++; $display("FAIL wrap_min_down: got %0d expected 59", load_minutes); end
    push(1'b0, 1'b1, 1'b0);
    checks++; if (load_minutes !== 6'd0) begin errors++; $display("FAIL wrap_min_up: got %0d expected 0", load_minutes); end
    push(1'b1, 1'b0, 1'b0);
    checks++; if (field !== 2'd3) begin errors++; $display("FAIL wrap_sec_field: got %0d expected 3", field); end
    push(1'b0, 1'b1, 1'b0);
    checks++; if (load_seconds !== 6'd0) begin errors++; $display("FAIL wrap_sec_up: got %0d expected 0", load_seconds); end
    push(1'b1, 1'b0, 1'b0);
    checks++; if (fsm_state !== 3'(IDLE)) begin errors++; $display("FAIL wrap_exit: got %0d expected %0d", fsm_state, IDLE); end
  endtask

  task automatic test_full_pass();
    int pulses;
    logic [4:0] got_h;
    logic [5:0] got_m;
    logic [5:0] got_s;
    pulses = 0; got_h = '0; got_m = '0; got_s = '0;
    set_cur(5'd13, 6'd45, 6'd30);
    push(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    checks++; if (field !== 2'd3) begin errors++; $display("FAIL pass_sec_field: got %0d expected 3", field); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL pass_no_early_load: got %0d expected 0", load); end
    set_cur(5'd1, 6'd2, 6'd3);
    @(negedge clk);
    set = 1'b1;
    for (int i = 0; i < D + 8; i++) begin
      @(negedge clk);
      if (load === 1'b1) begin
        pulses++; got_h = load_hours; got_m = load_minutes; got_s = load_seconds;
      end
    end
    set = 1'b0;
    repeat (D + 4) @(negedge clk);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL pass_pulse_count: got %0d expected 1", pulses); end
    checks++; if (got_h !== 5'd15) begin errors++; $display("FAIL pass_load_hours: got %0d expected 15", got_h); end
    checks++; if (got_m !== 6'd45) begin errors++; $display("FAIL pass_load_minutes: got %0d expected 45", got_m); end
    checks++; if (got_s !== 6'd30) begin errors++; $display("FAIL pass_load_seconds: got %0d expected 30", got_s); end
    checks++; if (field !== 2'd0) begin errors++; $display("FAIL pass_field_idle: got %0d expected 0", field); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL pass_editing_idle: got %0d expected 0", editing); end
    checks++; if (fsm_state !== 3'(IDLE)) begin errors++; $display("FAIL pass_state_idle: got %0d expected %0d", fsm_state, IDLE); end
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    base = load_seen;
    set_cur(5'd5, 6'd62, 6'd30);
    push(1'b1, 1'b0, 1'b0);
    checks++; if (load_minutes !== 6'd0) begin errors++; $display("FAIL capture_range_min: got %0d expected 0", load_minutes); end
    checks++; if (load_hours !== 5'd5) begin errors++; $display("FAIL capture_range_h: got %0d expected 5", load_hours); end
    repeat (1000) @(negedge clk);
    checks++; if (editing !== 1'b1) begin errors++; $display("FAIL timeout_early: got editing %0d expected 1", editing); end
    repeat (40) @(negedge clk);
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL timeout_editing: got %0d expected 0", editing); end
    checks++; if (field !== 2'd0) begin errors++; $display("FAIL timeout_field: got %0d expected 0", field); end
    checks++; if (load_seen !== base) begin errors++; $display("FAIL timeout_no_load: got %0d pulses expected %0d", load_seen, base); end
    checks++; if (load_hours !== 5'd5) begin errors++; $display("FAIL timeout_keep_h: got %0d expected 5", load_hours); end
  endtask

  task automatic test_reset_mid_edit();
    int base;
    set_cur(5'd7, 6'd8, 6'd9);
    push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    checks++; if (field !== 2'd2) begin errors++; $display("FAIL mid_field_min: got %0d expected 2", field); end
    base = load_seen;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (field !== 2'd0) begin errors++; $display("FAIL mid_async_field: got %0d expected 0", field); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL mid_async_editing: got %0d expected 0", editing); end
    checks++; if (load_minutes !== 6'd0) begin errors++; $display("FAIL mid_async_minutes: got %0d expected 0", load_minutes); end
    checks++; if (fsm_state !== 3'(IDLE)) begin errors++; $display("FAIL mid_async_state: got %0d expected %0d", fsm_state, IDLE); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (D + 4) @(negedge clk);
    checks++; if (load_seen !== base) begin errors++; $display("FAIL mid_no_load: got %0d pulses expected %0d", load_seen, base); end
  endtask

`ifdef TIME_SET_BLINK_EN
  task automatic test_blink();
    do_reset();
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_idle: got %0d expected 0", blink); end
    set_cur(5'd1, 6'd2, 6'd3);
    @(negedge clk);
    set = 1'b1;
    repeat (D + 2) @(negedge clk);
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_entry: got %0d expected 1", blink); end
    repeat (7) @(negedge clk);
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_hold: got %0d expected 1", blink); end
    @(negedge clk);
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_toggle: got %0d expected 0", blink); end
    set = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_toggle2: got %0d expected 1", blink); end
    do_reset();
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_after_reset: got %0d expected 0", blink); end
  endtask
`endif

  // sequence and final report
  initial begin
    test_reset();
    test_capture_latency();
    test_glitch_simultaneous();
    test_wrap();
    test_full_pass();
    test_timeout();
    test_reset_mid_edit();
`ifdef TIME_SET_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
